// File: rtl/clk_gate_ctrl_if.sv
// Per-channel handshake bundle between clk_gate_ctrl (master) and the gated
// sub-blocks / clock gating cells (slave).
interface clk_gate_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] wake_req;
    logic [NUM_CH-1:0] sleep_ack;
    logic [NUM_CH-1:0] sleep_req;
    logic [NUM_CH-1:0] icg_en;
    logic [NUM_CH-1:0] icg_te;
    logic [NUM_CH-1:0] ch_rdy;

    modport master (
        input  busy, wake_req, sleep_ack,
        output sleep_req, icg_en, icg_te, ch_rdy
    );

    modport slave (
        output busy, wake_req, sleep_ack,
        input  sleep_req, icg_en, icg_te, ch_rdy
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: one Moore FSM per channel driving ICG E/TE pins.
// Optional gated-cycle statistics are enabled by defining CLK_GATE_CTRL_STAT_EN.
module clk_gate_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int CW       = 8,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cg_en,
    input  logic        test_mode,
    input  logic [3:0]  cnt_sel,
    output logic [15:0] cnt_val,
    clk_gate_ctrl_if.master cg
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_IDLE,
        ST_REQ,
        ST_OFF,
        ST_WAKE
    } state_t;

    localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYC - 1);
    localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYC - 1);

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CW-1:0]     cnt_q   [NUM_CH];
    logic [CW-1:0]     cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] active;

    // Global disable counts as activity so no channel can start a new sleep.
    assign active = cg.busy | cg.wake_req | {NUM_CH{~cg_en}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_RUN;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_RUN: begin
                    if (!active[i]) begin
                        cnt_d[i]   = IDLE_LD;
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (active[i]) begin
                        state_d[i] = ST_RUN;
                    end else if (cnt_q[i] == '0) begin
                        state_d[i] = ST_REQ;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
                ST_REQ: begin
                    // Activity beats a simultaneous acknowledge.
                    if (active[i]) begin
                        state_d[i] = ST_RUN;
                    end else if (cg.sleep_ack[i]) begin
                        state_d[i] = ST_OFF;
                    end
                end
                ST_OFF: begin
                    // busy is meaningless here: the sub-block has no clock.
                    if (cg.wake_req[i] || !cg_en) begin
                        cnt_d[i]   = WAKE_LD;
                        state_d[i] = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = ST_RUN;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        cg.icg_en    = '0;
        cg.sleep_req = '0;
        cg.ch_rdy    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cg.icg_en[i]    = (state_q[i] != ST_OFF);
            cg.sleep_req[i] = (state_q[i] == ST_REQ);
            cg.ch_rdy[i]    = (state_q[i] == ST_RUN) || (state_q[i] == ST_IDLE) ||
                              (state_q[i] == ST_REQ);
        end
    end

    assign cg.icg_te = {NUM_CH{test_mode}};

`ifdef CLK_GATE_CTRL_STAT_EN
    logic [15:0] stat_q [NUM_CH];
    logic [15:0] sel_val;
    logic [15:0] cnt_val_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stat_q[i] <= '0;
            end
            cnt_val_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (state_q[i] == ST_OFF) begin
                    stat_q[i] <= sat_inc(stat_q[i]);
                end
            end
            cnt_val_q <= sel_val;
        end
    end

    // Selects beyond the implemented channels fall through to zero.
    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_sel == 4'(i)) begin
                sel_val = stat_q[i];
            end
        end
    end

    assign cnt_val = cnt_val_q;
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_val        = '0;
`endif

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Multi-channel clock-gating controller that drives the enable (E) and test-enable (TE) pins of one integrated clock gating cell per channel. Each channel watches its sub-block's activity and sleeps after a programmable idle interval, using a request/acknowledge handshake. It wakes on request and holds `ch_rdy` low until the re-enabled clock has settled. It sits in the always-on clock domain, alongside the gating cells it controls.

## Interface
- `NUM_CH`, 4: number of gated channels (1..16).
- `CW`, 8: width of the per-channel down-counter.
- `IDLE_CYC`, 16: idle cycles before a sleep request (1..2^CW-1).
- `WAKE_CYC`, 2: cycles after the enable rises before `ch_rdy` (1..2^CW-1).
- `clk` in 1: ungated always-on clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cg_en` in 1: global gating enable; 0 forces every channel to RUN.
- `test_mode` in 1: DFT scan mode.
- `busy` in NUM_CH: per-channel activity flag from the sub-block.
- `wake_req` in NUM_CH: per-channel wake request (level).
- `sleep_ack` in NUM_CH: sub-block confirms it is quiescent.
- `sleep_req` out NUM_CH: sleep request to the sub-block.
- `icg_en` out NUM_CH: to the gating cell E pin.
- `icg_te` out NUM_CH: to the gating cell TE pin; every bit equals `test_mode`, combinational.
- `ch_rdy` out NUM_CH: channel clock running and stable.
- `cnt_sel` in 4: channel select for the statistics read (macro only).
- `cnt_val` out 16: gated-cycle count of the selected channel (macro only).

## Operation
- Each channel has its own Moore FSM: RUN, IDLE, REQ, OFF, WAKE.
- Outputs decode from the registered state:
  - `icg_en` = 0 only in OFF.
  - `sleep_req` = 1 only in REQ.
  - `ch_rdy` = 1 in RUN, IDLE and REQ.
- "active" = `busy` | `wake_req` | !`cg_en`.
- RUN:
  - !active: load counter with IDLE_CYC-1, go to IDLE.
- IDLE:
  - active: go to RUN.
  - counter == 0: go to REQ.
  - otherwise: decrement.
- REQ:
  - active: go to RUN; the request drops in the next cycle.
  - `sleep_ack` and !active: go to OFF.
  - Active wins when both happen in the same cycle.
- OFF:
  - `wake_req` or !`cg_en`: load counter with WAKE_CYC-1, go to WAKE.
  - `busy` is ignored in OFF; the sub-block is unclocked.
- WAKE:
  - counter == 0: go to RUN.
  - otherwise: decrement.
  - Wake cannot be aborted; sleep is reconsidered only from RUN.
- `test_mode` = 1: `icg_te` = 1, so cells pass the clock regardless of `icg_en`. The FSM keeps running.
- Channels are fully independent; there is no arbitration between them.
- Reset, including mid-operation:
  - every FSM goes to RUN and counters clear.
  - `icg_en` = all 1, `ch_rdy` = all 1, `sleep_req` = 0, `cnt_val` = 0.
  - Reset during OFF therefore re-enables the clock on the next cycle, with no WAKE delay.

## Timing
- Sleep path: `busy` falls before edge k.
  - IDLE from edge k.
  - REQ after IDLE_CYC more edges: `sleep_req` high in cycle k+IDLE_CYC+1.
  - `sleep_ack` sampled at edge m: `icg_en` low in cycle m+1.
- Wake path: `wake_req` sampled high in OFF at edge k.
  - `icg_en` = 1 from cycle k+1.
  - `ch_rdy` = 1 from cycle k+1+WAKE_CYC.
- `sleep_ack` is level-sampled. The sub-block must hold it until `sleep_req` drops.
- `wake_req` must stay high until `ch_rdy` rises.
- All inputs are synchronous to `clk`.

## Configuration
- Macro: `CLK_GATE_CTRL_STAT_EN`.
- Defined:
  - each channel has a 16-bit counter incremented every cycle the channel is in OFF.
  - the counter saturates at 0xFFFF and clears on reset.
  - `cnt_val` is the registered count of channel `cnt_sel`, one-cycle latency.
  - `cnt_sel` >= NUM_CH reads 0.
- Undefined: the counters are absent, `cnt_val` is tied to 0 and `cnt_sel` is unused.

## Test plan
- Reset then idle: rst_n low 2 cycles, `busy`=0, `wake_req`=0, `cg_en`=1, IDLE_CYC=16 -> `sleep_req[0]` rises 17 cycles after reset release; ack same cycle -> `icg_en[0]`=0 next cycle, `ch_rdy[0]`=0.
- Wake: channel 0 in OFF, `wake_req[0]` pulse held -> `icg_en[0]`=1 one cycle later, `ch_rdy[0]`=1 two cycles after that (WAKE_CYC=2).
- Abort: `busy[1]` rises in the cycle `sleep_ack[1]` arrives while in REQ -> channel returns to RUN, `icg_en[1]` never drops, `sleep_req[1]` low next cycle.
- Global disable: all channels OFF, `cg_en` 1->0 -> all `icg_en`=1 next cycle, all `ch_rdy`=1 after WAKE_CYC, with no new sleep while `cg_en`=0.
- Reset mid-sleep: rst_n low while channel 2 in OFF -> `icg_en[2]`=1, `ch_rdy[2]`=1 the cycle after the reset edge.
- Stats (macro defined): channel 3 held OFF 300 cycles, `cnt_sel`=3 -> `cnt_val`=300; `cnt_sel`=15 with NUM_CH=4 -> 0.
